// File: rtl/shift_reg_sequencer.sv
// Sequencer for a WIDTH-bit parallel-load shift register: load a word, shift N times, pulse done.
// Optional build macro SEQ_ROTATE_EN makes the latched rotate bit feed q[WIDTH-1] back into q[0].
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             resetp,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_shifts,
    input  logic             cmd_fill,
    input  logic             cmd_rotate,
    input  logic [WIDTH-1:0] reg_q,
    output logic             reg_loadn,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_w,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic             rotate_q, rotate_d;

    logic             accept;
    logic [CW-1:0]    shifts_clamped;
    logic             shift_bit;

    assign accept         = cmd_valid && (state_q == S_IDLE);
    assign shifts_clamped = (cmd_shifts > CW'(WIDTH)) ? CW'(WIDTH) : cmd_shifts;

`ifdef SEQ_ROTATE_EN
    assign shift_bit = rotate_q ? reg_q[WIDTH-1] : fill_q;
`else
    // Rotate select is latched but deliberately has no effect in this build.
    logic unused_rotate_q;
    assign unused_rotate_q = rotate_q;
    assign shift_bit       = fill_q;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        fill_d    = fill_q;
        rotate_d  = rotate_q;
        cmd_ready = 1'b0;
        reg_loadn = 1'b1;
        reg_d     = reg_q;
        reg_w     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    data_d   = cmd_data;
                    count_d  = shifts_clamped;
                    fill_d   = cmd_fill;
                    rotate_d = cmd_rotate;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                reg_d   = data_q;
                state_d = (count_q == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                reg_loadn = 1'b0;
                reg_d     = '0;
                reg_w     = shift_bit;
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (resetp) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            data_q   <= '0;
            fill_q   <= 1'b0;
            rotate_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            rotate_q <= rotate_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer driving a 4-bit parallel-load shift register with reg_q fed back.
// Expected register contents come from an arithmetic model of load-then-shift.
module tb_shift_reg_sequencer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
`ifdef SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetp = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_shifts = '0;
    logic          cmd_fill = 1'b0;
    logic          cmd_rotate = 1'b0;
    logic [W-1:0]  sr_q = '0;
    logic          reg_loadn;
    logic [W-1:0]  reg_d;
    logic          reg_w;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_sequencer #(.WIDTH(W)) dut (
        .clock      (clock),
        .resetp     (resetp),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_shifts (cmd_shifts),
        .cmd_fill   (cmd_fill),
        .cmd_rotate (cmd_rotate),
        .reg_q      (sr_q),
        .reg_loadn  (reg_loadn),
        .reg_d      (reg_d),
        .reg_w      (reg_w),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // The physical register being controlled.
    always @(posedge clock) begin
        sr_q <= reg_loadn ? reg_d : {sr_q[W-2:0], reg_w};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value of the register after loading data and applying n shifts.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] data, input int n,
                                             input logic fill, input logic rot);
        int v = int'(data);
        for (int j = 0; j < n; j++) begin
            int b = (ROT_EN && rot) ? (v / (2 ** (W - 1))) % 2 : int'(fill);
            v = (v * 2 + b) % (2 ** W);
        end
        return W'(v);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !cmd_ready; i++) next_cycle();
        check({tag, " ready_before_cmd"}, cmd_ready, 1);
    endtask

    // Starts in the LOAD cycle and ends in the DONE cycle of one command.
    task automatic track_cmd(input string tag, input logic [W-1:0] data, input logic [CW-1:0] sh,
                             input logic fill, input logic rot);
        int n;
        int c;
        bit seen;
        n    = (int'(sh) > W) ? W : int'(sh);
        c    = 1;
        seen = 1'b0;
        while (!seen && c <= W + 4) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " ready_low"}, cmd_ready, 0);
            check({tag, " loadn"}, reg_loadn, (c == 1 || c >= n + 2) ? 1 : 0);
            if (c == 1) check({tag, " load_data"}, reg_d, data);
            if (c >= 2) check({tag, " reg_q"}, sr_q, model_q(data, (c - 2 < n) ? c - 2 : n, fill, rot));
            if (done) seen = 1'b1;
            else begin
                next_cycle();
                c++;
            end
        end
        check({tag, " done_cycle"}, c, n + 2);
    endtask

    task automatic run_cmd(input string tag, input logic [W-1:0] data, input logic [CW-1:0] sh,
                           input logic fill, input logic rot);
        wait_ready(tag);
        cmd_valid  = 1'b1;
        cmd_data   = data;
        cmd_shifts = sh;
        cmd_fill   = fill;
        cmd_rotate = rot;
        next_cycle();
        cmd_valid  = 1'b0;
        cmd_data   = W'($urandom);
        cmd_shifts = CW'($urandom);
        cmd_fill   = 1'($urandom);
        cmd_rotate = 1'($urandom);
        track_cmd(tag, data, sh, fill, rot);
        next_cycle();
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_ready"}, cmd_ready, 1);
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] held;

        // Reset state.
        resetp = 1'b1;
        next_cycle();
        next_cycle();
        resetp = 1'b0;
        check("reset busy", busy, 0);
        check("reset ready", cmd_ready, 1);
        check("reset done", done, 0);
        check("reset loadn", reg_loadn, 1);
        check("reset reg_w", reg_w, 0);

        // Reset in the middle of shifting aborts without done.
        wait_ready("abort");
        cmd_valid  = 1'b1;
        cmd_data   = 4'b1011;
        cmd_shifts = 3'd4;
        cmd_fill   = 1'b0;
        cmd_rotate = 1'b0;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        check("abort shifting", reg_loadn, 0);
        resetp = 1'b1;
        next_cycle();
        resetp = 1'b0;
        check("abort busy", busy, 0);
        check("abort ready", cmd_ready, 1);
        check("abort done", done, 0);
        for (int i = 0; i < 6; i++) begin
            check("abort no_done", done, 0);
            next_cycle();
        end

        // Basic load and two shifts, then hold.
        run_cmd("basic", 4'b1011, 3'd2, 1'b0, 1'b0);
        check("basic final", sr_q, 4'b1100);
        for (int i = 0; i < 10; i++) begin
            check("hold reg_q", sr_q, 4'b1100);
            check("hold done", done, 0);
            next_cycle();
        end

        run_cmd("zero", 4'b0101, 3'd0, 1'b0, 1'b0);
        check("zero final", sr_q, 4'b0101);

        run_cmd("clamp", 4'b0000, 3'd7, 1'b1, 1'b0);
        check("clamp final", sr_q, 4'b1111);

        // Back-pressure: cmd_valid held across two commands.
        wait_ready("bp");
        cmd_valid  = 1'b1;
        cmd_data   = 4'b1000;
        cmd_shifts = 3'd1;
        cmd_fill   = 1'b0;
        cmd_rotate = 1'b0;
        next_cycle();
        cmd_data   = 4'b0001;
        cmd_shifts = 3'd1;
        cmd_fill   = 1'b1;
        track_cmd("bp1", 4'b1000, 3'd1, 1'b0, 1'b0);
        next_cycle();
        check("bp idle_ready", cmd_ready, 1);
        check("bp idle_busy", busy, 0);
        next_cycle();
        cmd_valid = 1'b0;
        track_cmd("bp2", 4'b0001, 3'd1, 1'b1, 1'b0);
        check("bp final", sr_q, 4'b0011);
        next_cycle();

        run_cmd("rotate", 4'b1001, 3'd1, 1'b0, 1'b1);
        check("rotate final", sr_q, ROT_EN ? 4'b0011 : 4'b0010);

        // Randomized commands with random idle gaps.
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0]  d;
            logic [CW-1:0] s;
            logic          f;
            logic          r;
            d = W'($urandom);
            s = CW'($urandom_range(0, 7));
            f = 1'($urandom);
            r = 1'($urandom);
            run_cmd("rand", d, s, f, r);
            held = sr_q;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                next_cycle();
                check("rand hold", sr_q, held);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
